mul_hilo_ctrl: RTL

//  Sequences the 2-stage Booth/Wallace multiplier (mul: 1 register stage, result valid the cycle after operands
//  are presented) for EXE-stage multiply ops, and owns the architectural HI/LO registers. Accepts one op via

---
 rtl/mul_hilo_ctrl_if.sv | 21 ++
 rtl/mul_hilo_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mul_hilo_ctrl_if.sv
// Request/response handshake bundle between the EXE stage and the multiply controller.
interface mul_hilo_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] req_src1;
    logic [31:0] req_src2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_lo;

    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready,
        input  req_ready, resp_valid, resp_lo
    );

    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready,
        output req_ready, resp_valid, resp_lo
    );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// Multiply sequencer: drives a 1-register-stage multiplier, owns HI/LO and handles MADD/MSUB accumulation.
module mul_hilo_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    mul_hilo_ctrl_if.slave        bus,
    input  logic                  flush,
    input  logic                  hilo_wr_hi,
    input  logic                  hilo_wr_lo,
    input  logic [31:0]           hilo_wdata,
    output logic                  mul_resetn,
    output logic                  mul_signed,
    output logic [31:0]           mul_x,
    output logic [31:0]           mul_y,
    input  logic [63:0]           mul_result,
    output logic [31:0]           hi,
    output logic [31:0]           lo
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ACC   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MUL   = 3'b110;

    logic [2:0]  state_r, state_nxt_s;
    logic [2:0]  op_r;
    logic [31:0] src1_r, src2_r;
    logic [63:0] prod_r;
    logic [31:0] hi_r, lo_r, resp_lo_r;
    logic        resp_valid_r;
    logic        acc_op_s, sub_op_s, accept_s;
    logic [63:0] acc_sum_s;

    assign mul_resetn     = ~reset;
    assign mul_x          = src1_r;
    assign mul_y          = src2_r;
    assign mul_signed     = ~op_r[0];
    assign bus.req_ready  = (state_r == S_IDLE) & ~flush;
    assign accept_s       = bus.req_valid & bus.req_ready;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_lo    = resp_lo_r;
    assign hi             = hi_r;
    assign lo             = lo_r;

    // Accumulate datapath: MADD* = 01x, MSUB* = 10x; sum wraps modulo 2^64.
    always_comb begin
        acc_op_s  = (op_r[2:1] == 2'b01) || (op_r[2:1] == 2'b10);
        sub_op_s  = (op_r[2:1] == 2'b10);
        if (sub_op_s) begin
            acc_sum_s = {hi_r, lo_r} - prod_r;
        end else begin
            acc_sum_s = {hi_r, lo_r} + prod_r;
        end
    end

    // Next-state logic; flush returns any busy state to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE:  if (accept_s) state_nxt_s = S_ISSUE; else state_nxt_s = S_IDLE;
            S_ISSUE: if (flush) state_nxt_s = S_IDLE; else state_nxt_s = S_WAIT;
            S_WAIT: begin
                if (flush)         state_nxt_s = S_IDLE;
                else if (acc_op_s) state_nxt_s = S_ACC;
                else               state_nxt_s = S_DONE;
            end
            S_ACC:   if (flush) state_nxt_s = S_IDLE; else state_nxt_s = S_DONE;
            S_DONE:  if (flush || bus.resp_ready) state_nxt_s = S_IDLE; else state_nxt_s = S_DONE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register and registered response-valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            resp_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            resp_valid_r <= (state_nxt_s == S_DONE);
        end
    end

    // Operand latch on request accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_r   <= 3'd0;
            src1_r <= 32'd0;
            src2_r <= 32'd0;
        end else if (accept_s) begin
            op_r   <= bus.req_op;
            src1_r <= bus.req_src1;
            src2_r <= bus.req_src2;
        end
    end

    // HI/LO, product and response registers; MTHI/MTLO only land while IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            prod_r    <= 64'd0;
            resp_lo_r <= 32'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (hilo_wr_hi) hi_r <= hilo_wdata;
                    if (hilo_wr_lo) lo_r <= hilo_wdata;
                end
                S_WAIT: begin
                    if (!flush) begin
                        if (acc_op_s) begin
                            prod_r <= mul_result;
                        end else if ((op_r == OP_MULT) || (op_r == OP_MULTU)) begin
                            {hi_r, lo_r} <= mul_result;
                            resp_lo_r    <= mul_result[31:0];
                        end else if (op_r == OP_MUL) begin
                            resp_lo_r <= mul_result[31:0];
                        end else begin
                            resp_lo_r <= 32'd0;
                        end
                    end
                end
                S_ACC: begin
                    if (!flush) begin
                        {hi_r, lo_r} <= acc_sum_s;
                        resp_lo_r    <= acc_sum_s[31:0];
                    end
                end
                default: begin
                    hi_r <= hi_r;
                end
            endcase
        end
    end
endmodule
